serial_adder_arbiter: RTL

- Shares one 2-bit serial adder (simpleadder) between NUM_REQ requesters, one transaction at a time.
- Accepts parallel 2-bit operand pairs through a per-requester valid/ready handshake and selects among requesters round-robin.
- Serializes the chosen operands into the adder, deserializes the 3-bit serial sum, and returns it with the requester ID on a single response channel that supports backpressure.

---
 rtl/serial_adder_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder_arbiter.sv
// serial_adder_arbiter: round-robin front end that shares one 2-bit serial
// adder between NUM_REQ requesters. Operands go in MSB first over two cycles,
// and the 3-bit serial sum is gathered back and returned with the requester
// ID on a single response channel that can be backpressured.
module serial_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_a,
  input  logic [2*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [2:0]           resp_sum,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 add_en_i,
  output logic                 add_ina,
  output logic                 add_inb,
  input  logic                 add_en_o,
  input  logic                 add_out
);

  // The adder has no reset, so six idle cycles are enough for any
  // half-finished transaction inside it to drain out.
  localparam int FLUSH_CYCLES = 6;
  localparam int CNT_MAX      = (TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam int SEL_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_SEND1, S_SEND0, S_WAITR, S_CAP1, S_CAP0, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [1:0]       a_q, a_d;
  logic [1:0]       b_q, b_d;
  logic [2:0]       sum_q, sum_d;
  logic             err_q, err_d;

  logic [1:0]       op_a [NUM_REQ];
  logic [1:0]       op_b [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [1:0]         grant_a, grant_b;
  logic [SEL_W-1:0]   scan_sel;

  // Split the packed operand buses into one 2-bit lane per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[2*gi +: 2];
      assign op_b[gi] = req_b[2*gi +: 2];
    end
  endgenerate

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_a   = '0;
    grant_b   = '0;
    scan_sel  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sel = SEL_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_any && req_valid[scan_sel]) begin
        grant_any       = 1'b1;
        grant[scan_sel] = 1'b1;
        grant_idx       = ID_W'(scan_sel);
        grant_a         = op_a[scan_sel];
        grant_b         = op_b[scan_sel];
      end
    end
  end

  // Next-state and datapath update for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    err_d   = err_q;
    case (state_q)
      S_FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (grant_any) begin
          id_d    = grant_idx;
          a_d     = grant_a;
          b_d     = grant_b;
          ptr_d   = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
          sum_d   = '0;
          err_d   = 1'b0;
          state_d = S_SEND1;
        end
      end
      S_SEND1: state_d = S_SEND0;
      S_SEND0: begin
        cnt_d   = '0;
        state_d = S_WAITR;
      end
      S_WAITR: begin
        // A strobe arriving on the last allowed cycle still counts as success.
        if (add_en_o) begin
          sum_d   = {add_out, 2'b00};
          state_d = S_CAP1;
        end else if ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          sum_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAP1: begin
        sum_d[1] = add_out;
        state_d  = S_CAP0;
      end
      S_CAP0: begin
        sum_d[0] = add_out;
        state_d  = S_RESP;
      end
      S_RESP: begin
        // After a timeout the adder may still be mid-flight, so drain it.
        if (resp_ready) begin
          cnt_d   = '0;
          state_d = err_q ? S_FLUSH : S_IDLE;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // State and datapath registers; reset lands in FLUSH so the adder drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FLUSH;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  // Adder-side signals come only from registered state, never from inputs.
  assign add_en_i   = (state_q == S_SEND1);
  assign add_ina    = (state_q == S_SEND1) ? a_q[1] : (state_q == S_SEND0) ? a_q[0] : 1'b0;
  assign add_inb    = (state_q == S_SEND1) ? b_q[1] : (state_q == S_SEND0) ? b_q[0] : 1'b0;

  assign req_ready  = (state_q == S_IDLE) ? grant : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
